dmadd_sequencer: RTL and testbench
==================================

Name: dmadd_sequencer

Overview:
- Drives the DMADD operand/control interface from the initiator side.
- Accepts a job command (insn) and a valid/ready stream of (index, data) operand beats.
- Generates the clear, init, load and run pulse sequence DMADD expects, then samples DMADD's out bus.
- Returns the sample as a result beat over a valid/ready handshake.
- Sits between the host/stream front-end and one DMADD instance; it is the only writer of DMADD's inputs.

Parameters:
- RUN_CYCLES, 18, number of consecutive dm_run=1 cycles per job; must cover the 16-entry sweep plus the hit/halt latency.
- CLR_CYCLES, 1, number of cycles dm_rst_n is held low before each job, to clear DMADD memory and accumulators.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  job request accepted when both cmd_valid and cmd_ready are high
- cmd_insn  in  2  00 MIN, 01 MAX, 10 MADD, 11 illegal
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accepted when both op_valid and op_ready are high
- op_index  in  4  operand index
- op_data  in  4  operand data (used by MADD only, forwarded unchanged otherwise)
- op_last  in  1  marks the final operand beat of the job
- dm_rst_n  out  1  DMADD rst_n, synchronous-low clear pulse
- dm_index  out  4  to DMADD index
- dm_data  out  4  to DMADD data
- dm_insn  out  2  to DMADD insn
- dm_load  out  1  to DMADD load
- dm_run  out  1  to DMADD run
- dm_out  in  12  from DMADD out
- res_valid  out  1  result beat valid
- res_ready  in  1  result beat accepted when both res_valid and res_ready are high
- res_data  out  12  sampled DMADD result
- res_err  out  1  job used illegal insn

Behaviour:
- All outputs are registered.
- Reset values:
  - cmd_ready=0, op_ready=0, res_valid=0, res_data=0, res_err=0.
  - dm_rst_n=0, dm_load=0, dm_run=0, dm_index=0, dm_data=0, dm_insn=0.
  - FSM in IDLE.
  - cmd_ready goes to 1 on the first clock after reset release.
- FSM states: IDLE, CLEAR, INIT, LOAD, RUN, SETTLE, RESULT.
- IDLE:
  - cmd_ready=1, dm_rst_n=1.
  - On cmd handshake, latch insn into dm_insn.
  - insn=11: go to RESULT with res_data=0 and res_err=1; no DMADD activity.
  - Otherwise go to CLEAR.
- CLEAR: dm_rst_n=0 for CLR_CYCLES cycles, then INIT.
- INIT: exactly one cycle with dm_rst_n=1, dm_load=0, dm_run=0 and dm_insn stable. This selects DMADD's initialise row. Then LOAD.
- LOAD:
  - op_ready=1.
  - A beat accepted in cycle N gives dm_load=1 with dm_index/dm_data = beat in cycle N+1. One dm_load pulse per beat; back-to-back beats give contiguous dm_load cycles.
  - No beat gives dm_load=0; DMADD holds in its init row.
  - A beat with op_last=1: op_ready drops in cycle N+1, then RUN begins in cycle N+2.
- RUN:
  - dm_run=1 and dm_load=0 for exactly RUN_CYCLES cycles.
  - dm_load and dm_run are never high in the same cycle.
- SETTLE: one cycle with dm_run=0. Capture dm_out into res_data at the end of this cycle. Then RESULT.
- RESULT:
  - res_valid=1.
  - res_data and res_err are held stable until the handshake.
  - On handshake, go to IDLE and clear res_err.
- dm_insn holds its value from command accept through RESULT.
- Zero-operand jobs are not supported. The first operand beat must follow the command, and the job stays in LOAD until op_last.
- op_valid outside LOAD is ignored; op_ready=0 there.
- cmd_valid outside IDLE is ignored; cmd_ready=0 there.
- Async reset mid-job: all state returns to reset values immediately and the partial job is discarded. The dm_rst_n=0 reset value also clears DMADD on its next clock.
- Width rules:
  - res_data is a direct 12-bit copy of dm_out, no arithmetic.
  - Run counter width is clog2(RUN_CYCLES+1).
  - Clear counter width is clog2(CLR_CYCLES+1).

Decomposition:
- Shared package dmadd_pkg holds:
  - Insn encodings: INSN_MIN=2'b00, INSN_MAX=2'b01, INSN_MADD=2'b10, INSN_ILLEGAL=2'b11.
  - DMADD_MEM_DEPTH=16.
  - DMADD_OUT_W=12.
  - The sequencer FSM state enum.
- Single module, no sub-module. The run/clear down-counter is inline; it is too small to justify a separate counter module.

Test Plan:
- Reset: assert rst_n=0 mid-RUN → all outputs at reset values in the same cycle. After release, cmd_ready=1 one cycle later and dm_run=0.
- MIN job, stub dm_out=12'h003: cmd insn=00, beats index 5,9,3 (last on 3) →
  - dm_rst_n low 1 cycle, then one INIT cycle.
  - 3 contiguous dm_load pulses carrying 5,9,3.
  - dm_run high exactly 18 cycles.
  - res_valid with res_data=12'h003, res_err=0.
- MADD job with gaps: insn=10, beats (4,2),(7,5) with op_valid low 3 cycles between →
  - dm_load pulses are non-contiguous, 2 total, with dm_data 2 then 5.
  - dm_insn=10 throughout.
  - Stub dm_out=12'h0A5 gives res_data=12'h0A5.
- Illegal insn=11 → no dm_load/dm_run/dm_rst_n activity; res_valid next-but-one cycle with res_data=0, res_err=1.
- Backpressure: hold res_ready=0 for 10 cycles → res_valid and res_data stable; cmd_ready=0; a new cmd_valid is ignored until the handshake.
- Protocol check: assertion that dm_load & dm_run is never 1. Back-to-back jobs produce a dm_rst_n low pulse before each INIT.

Source files
------------

// File: rtl/dmadd_pkg.sv
// Shared definitions for the DMADD sequencer: instruction encodings, DMADD geometry
// and the sequencer state enum.
package dmadd_pkg;

   localparam logic [1:0] INSN_MIN     = 2'b00;
   localparam logic [1:0] INSN_MAX     = 2'b01;
   localparam logic [1:0] INSN_MADD    = 2'b10;
   localparam logic [1:0] INSN_ILLEGAL = 2'b11;

   localparam int DMADD_MEM_DEPTH = 16;
   localparam int DMADD_IDX_W     = $clog2(DMADD_MEM_DEPTH);
   localparam int DMADD_DATA_W    = 4;
   localparam int DMADD_OUT_W     = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_INIT,
      ST_LOAD,
      ST_RUN,
      ST_SETTLE,
      ST_RESULT
   } seq_state_e;

endpackage

// File: rtl/dmadd_sequencer_if.sv
// Bundle of the host command/operand/result streams and the DMADD control bus.
// master = the sequencer; slave = host front-end plus the DMADD instance.
interface dmadd_sequencer_if;
   import dmadd_pkg::*;

   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [1:0]              cmd_insn;

   logic                    op_valid;
   logic                    op_ready;
   logic [DMADD_IDX_W-1:0]  op_index;
   logic [DMADD_DATA_W-1:0] op_data;
   logic                    op_last;

   logic                    dm_rst_n;
   logic [DMADD_IDX_W-1:0]  dm_index;
   logic [DMADD_DATA_W-1:0] dm_data;
   logic [1:0]              dm_insn;
   logic                    dm_load;
   logic                    dm_run;
   logic [DMADD_OUT_W-1:0]  dm_out;

   logic                    res_valid;
   logic                    res_ready;
   logic [DMADD_OUT_W-1:0]  res_data;
   logic                    res_err;

   modport master (
      input  cmd_valid, cmd_insn, op_valid, op_index, op_data, op_last, dm_out, res_ready,
      output cmd_ready, op_ready, dm_rst_n, dm_index, dm_data, dm_insn, dm_load, dm_run,
             res_valid, res_data, res_err
   );

   modport slave (
      output cmd_valid, cmd_insn, op_valid, op_index, op_data, op_last, dm_out, res_ready,
      input  cmd_ready, op_ready, dm_rst_n, dm_index, dm_data, dm_insn, dm_load, dm_run,
             res_valid, res_data, res_err
   );

endinterface

// File: rtl/dmadd_sequencer.sv
// Initiator-side sequencer for one DMADD: clear, init, load beats, run sweep,
// then sample DMADD's out bus and return it as a result beat. All outputs registered.
module dmadd_sequencer
   import dmadd_pkg::*;
#(
   parameter int RUN_CYCLES = 18,
   parameter int CLR_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   dmadd_sequencer_if.master bus
);

   localparam int RUN_W = $clog2(RUN_CYCLES + 1);
   localparam int CLR_W = $clog2(CLR_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_LOAD = RUN_W'(RUN_CYCLES);
   localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES);

   seq_state_e              state_reg, state_next;
   logic [RUN_W-1:0]        run_cnt_reg, run_cnt_next;
   logic [CLR_W-1:0]        clr_cnt_reg, clr_cnt_next;
   logic                    last_reg, last_next;

   logic                    cmd_ready_reg, cmd_ready_next;
   logic                    op_ready_reg, op_ready_next;
   logic                    dm_rst_n_reg, dm_rst_n_next;
   logic [DMADD_IDX_W-1:0]  dm_index_reg, dm_index_next;
   logic [DMADD_DATA_W-1:0] dm_data_reg, dm_data_next;
   logic [1:0]              dm_insn_reg, dm_insn_next;
   logic                    dm_load_reg, dm_load_next;
   logic                    dm_run_reg, dm_run_next;
   logic                    res_valid_reg, res_valid_next;
   logic [DMADD_OUT_W-1:0]  res_data_reg, res_data_next;
   logic                    res_err_reg, res_err_next;

   logic cmd_fire, op_fire, res_fire;

   assign cmd_fire = bus.cmd_valid & cmd_ready_reg;
   assign op_fire  = bus.op_valid & op_ready_reg;
   assign res_fire = res_valid_reg & bus.res_ready;

   // Output values are computed for the state being entered, so every pin is a flop.
   always_comb begin
      state_next     = state_reg;
      run_cnt_next   = run_cnt_reg;
      clr_cnt_next   = clr_cnt_reg;
      last_next      = last_reg;
      cmd_ready_next = 1'b0;
      op_ready_next  = 1'b0;
      dm_rst_n_next  = 1'b1;
      dm_index_next  = dm_index_reg;
      dm_data_next   = dm_data_reg;
      dm_insn_next   = dm_insn_reg;
      dm_load_next   = 1'b0;
      dm_run_next    = 1'b0;
      res_valid_next = res_valid_reg;
      res_data_next  = res_data_reg;
      res_err_next   = res_err_reg;

      case (state_reg)
         ST_IDLE: begin
            cmd_ready_next = 1'b1;
            if (cmd_fire) begin
               cmd_ready_next = 1'b0;
               dm_insn_next   = bus.cmd_insn;
               if (bus.cmd_insn == INSN_ILLEGAL) begin
                  state_next     = ST_RESULT;
                  res_valid_next = 1'b1;
                  res_data_next  = '0;
                  res_err_next   = 1'b1;
               end else begin
                  state_next    = ST_CLEAR;
                  dm_rst_n_next = 1'b0;
                  clr_cnt_next  = CLR_LOAD;
               end
            end
         end
         ST_CLEAR: begin
            if (clr_cnt_reg > CLR_W'(1)) begin
               dm_rst_n_next = 1'b0;
               clr_cnt_next  = clr_cnt_reg - CLR_W'(1);
            end else begin
               state_next = ST_INIT;
            end
         end
         ST_INIT: begin
            state_next    = ST_LOAD;
            op_ready_next = 1'b1;
            last_next     = 1'b0;
         end
         ST_LOAD: begin
            // The last beat's load pulse still goes out; RUN starts the cycle after it.
            if (last_reg) begin
               state_next   = ST_RUN;
               dm_run_next  = 1'b1;
               run_cnt_next = RUN_LOAD;
            end else begin
               op_ready_next = 1'b1;
               if (op_fire) begin
                  dm_load_next  = 1'b1;
                  dm_index_next = bus.op_index;
                  dm_data_next  = bus.op_data;
                  if (bus.op_last) begin
                     op_ready_next = 1'b0;
                     last_next     = 1'b1;
                  end
               end
            end
         end
         ST_RUN: begin
            if (run_cnt_reg > RUN_W'(1)) begin
               dm_run_next  = 1'b1;
               run_cnt_next = run_cnt_reg - RUN_W'(1);
            end else begin
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            state_next     = ST_RESULT;
            res_valid_next = 1'b1;
            res_data_next  = bus.dm_out;
            res_err_next   = 1'b0;
         end
         ST_RESULT: begin
            if (res_fire) begin
               state_next     = ST_IDLE;
               res_valid_next = 1'b0;
               res_err_next   = 1'b0;
               cmd_ready_next = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         run_cnt_reg   <= '0;
         clr_cnt_reg   <= '0;
         last_reg      <= 1'b0;
         cmd_ready_reg <= 1'b0;
         op_ready_reg  <= 1'b0;
         dm_rst_n_reg  <= 1'b0;
         dm_index_reg  <= '0;
         dm_data_reg   <= '0;
         dm_insn_reg   <= '0;
         dm_load_reg   <= 1'b0;
         dm_run_reg    <= 1'b0;
         res_valid_reg <= 1'b0;
         res_data_reg  <= '0;
         res_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         run_cnt_reg   <= run_cnt_next;
         clr_cnt_reg   <= clr_cnt_next;
         last_reg      <= last_next;
         cmd_ready_reg <= cmd_ready_next;
         op_ready_reg  <= op_ready_next;
         dm_rst_n_reg  <= dm_rst_n_next;
         dm_index_reg  <= dm_index_next;
         dm_data_reg   <= dm_data_next;
         dm_insn_reg   <= dm_insn_next;
         dm_load_reg   <= dm_load_next;
         dm_run_reg    <= dm_run_next;
         res_valid_reg <= res_valid_next;
         res_data_reg  <= res_data_next;
         res_err_reg   <= res_err_next;
      end
   end

   assign bus.cmd_ready = cmd_ready_reg;
   assign bus.op_ready  = op_ready_reg;
   assign bus.dm_rst_n  = dm_rst_n_reg;
   assign bus.dm_index  = dm_index_reg;
   assign bus.dm_data   = dm_data_reg;
   assign bus.dm_insn   = dm_insn_reg;
   assign bus.dm_load   = dm_load_reg;
   assign bus.dm_run    = dm_run_reg;
   assign bus.res_valid = res_valid_reg;
   assign bus.res_data  = res_data_reg;
   assign bus.res_err   = res_err_reg;

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Bench for dmadd_sequencer: directed and random jobs against a per-job behavioural
// model of the DMADD control sequence, with a stub DMADD output bus.
module tb_dmadd_sequencer;
   import dmadd_pkg::*;

   localparam int RUN_CYCLES = 18;
   localparam int CLR_CYCLES = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] stub_val = '0;
   int          n_chk = 0;
   int          n_bad = 0;

   dmadd_sequencer_if bus ();

   dmadd_sequencer #(
      .RUN_CYCLES(RUN_CYCLES),
      .CLR_CYCLES(CLR_CYCLES)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Stub DMADD: the settled answer only when not running, its complement mid-sweep.
   always_comb bus.dm_out = bus.dm_run ? ~stub_val : stub_val;

   always @(posedge clk) assert (!(bus.dm_load && bus.dm_run));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
      chk({tag, "_op_ready"},  32'(bus.op_ready), 0);
      chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
      chk({tag, "_res_data"},  32'(bus.res_data), 0);
      chk({tag, "_res_err"},   32'(bus.res_err), 0);
      chk({tag, "_dm_rst_n"},  32'(bus.dm_rst_n), 0);
      chk({tag, "_dm_load"},   32'(bus.dm_load), 0);
      chk({tag, "_dm_run"},    32'(bus.dm_run), 0);
      chk({tag, "_dm_index"},  32'(bus.dm_index), 0);
      chk({tag, "_dm_data"},   32'(bus.dm_data), 0);
      chk({tag, "_dm_insn"},   32'(bus.dm_insn), 0);
   endtask

   // ---------------- model / compare process state ----------------
   bit          in_job = 0, fire_prev = 0, res_prev = 0, hold_prev = 0;
   bit          run_p1 = 0, run_p2 = 0, exp_err = 0, ready_seen = 0;
   logic [3:0]  idx_prev = '0, dat_prev = '0;
   logic [1:0]  job_insn = '0;
   logic [11:0] exp_res = '0, res_data_prev = '0;
   int          last_age = -1, n_beats = 0, n_loads = 0, n_clr = 0, post_clr = 0;
   int          run_len = 0, runs_done = 0, jobs_done = 0, mon_cyc = 0;
   logic [3:0]  ld_idx [16];
   logic [3:0]  ld_dat [16];
   int          ld_cyc [16];

   initial begin
      forever begin
         @(negedge clk);
         mon_cyc++;
         if (!rst_n) begin
            in_job = 0; fire_prev = 0; res_prev = 0; hold_prev = 0;
            run_p1 = 0; run_p2 = 0; last_age = -1; run_len = 0;
         end else begin
            chk("load_run_excl", 32'(bus.dm_load & bus.dm_run), 0);
            chk("dm_load_follows_beat", 32'(bus.dm_load), 32'(fire_prev));
            if (fire_prev) begin
               chk("dm_index", 32'(bus.dm_index), 32'(idx_prev));
               chk("dm_data", 32'(bus.dm_data), 32'(dat_prev));
            end
            if (last_age >= 0) begin
               last_age++;
               if (last_age == 1) begin
                  chk("op_ready_after_last", 32'(bus.op_ready), 0);
                  chk("run_not_yet", 32'(bus.dm_run), 0);
               end else begin
                  chk("run_start", 32'(bus.dm_run), 1);
                  last_age = -1;
               end
            end
            if (!in_job) begin
               chk("idle_op_ready", 32'(bus.op_ready), 0);
               chk("idle_res_valid", 32'(bus.res_valid), 0);
               chk("idle_dm_run", 32'(bus.dm_run), 0);
            end else begin
               chk("busy_cmd_ready", 32'(bus.cmd_ready), 0);
               chk("dm_insn_hold", 32'(bus.dm_insn), 32'(job_insn));
               if (exp_err) begin
                  chk("ill_op_ready", 32'(bus.op_ready), 0);
                  chk("ill_dm_rst_n", 32'(bus.dm_rst_n), 1);
               end
               if (!bus.dm_rst_n) n_clr++;
               else if (n_clr > 0) begin
                  if (bus.op_ready && !ready_seen) begin
                     chk("init_one_cycle", 32'(post_clr), 1);
                     ready_seen = 1;
                  end
                  post_clr++;
               end
               if (bus.dm_load) begin
                  if (n_loads < 16) begin
                     ld_idx[n_loads] = bus.dm_index;
                     ld_dat[n_loads] = bus.dm_data;
                     ld_cyc[n_loads] = mon_cyc;
                  end
                  n_loads++;
               end
               if (bus.dm_run) run_len++;
               else if (run_len > 0) begin
                  chk("run_len", 32'(run_len), RUN_CYCLES);
                  runs_done++;
                  run_len = 0;
               end
               if (bus.res_valid && !res_prev) begin
                  chk("res_data", 32'(bus.res_data), 32'(exp_res));
                  chk("res_err", 32'(bus.res_err), 32'(exp_err));
                  if (exp_err) begin
                     chk("ill_loads", 32'(n_loads), 0);
                     chk("ill_runs", 32'(runs_done + run_len), 0);
                     chk("ill_clear", 32'(n_clr), 0);
                  end else begin
                     chk("loads_eq_beats", 32'(n_loads), 32'(n_beats));
                     chk("one_run", 32'(runs_done), 1);
                     chk("clear_len", 32'(n_clr), CLR_CYCLES);
                     chk("settle_cycle", 32'({run_p2, run_p1}), 32'(2'b10));
                  end
               end
               if (res_prev && hold_prev) begin
                  chk("res_hold_valid", 32'(bus.res_valid), 1);
                  chk("res_hold_data", 32'(bus.res_data), 32'(res_data_prev));
               end
            end
            if (in_job && bus.res_valid && bus.res_ready) begin
               $display("job %0d insn=%02b beats=%0d res_data=%03h res_err=%0b",
                        jobs_done, job_insn, n_beats, bus.res_data, bus.res_err);
               in_job = 0;
               jobs_done++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
               in_job = 1;
               job_insn = bus.cmd_insn;
               exp_err = (bus.cmd_insn == INSN_ILLEGAL);
               exp_res = exp_err ? 12'h000 : stub_val;
               n_beats = 0; n_loads = 0; n_clr = 0; post_clr = 0;
               run_len = 0; runs_done = 0; ready_seen = 0;
            end
            fire_prev = bus.op_valid && bus.op_ready;
            idx_prev = bus.op_index;
            dat_prev = bus.op_data;
            if (fire_prev) begin
               n_beats++;
               if (bus.op_last) last_age = 0;
            end
            hold_prev = bus.res_valid && !bus.res_ready;
            res_prev = bus.res_valid;
            res_data_prev = bus.res_data;
            run_p2 = run_p1;
            run_p1 = bus.dm_run;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [3:0] beat_idx [16];
   logic [3:0] beat_dat [16];
   int         beat_gap [16];

   // All driver tasks start and end one time unit after a rising edge.
   task automatic send_cmd(input logic [1:0] insn);
      bit ok = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_insn = insn;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      chk("cmd_accept", 32'(ok), 1);
   endtask

   task automatic send_beat(input logic [3:0] idx, input logic [3:0] dat, input bit last);
      bit ok = 0;
      bus.op_valid = 1'b1;
      bus.op_index = idx;
      bus.op_data = dat;
      bus.op_last = last;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.op_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      bus.op_last = 1'b0;
      chk("op_accept", 32'(ok), 1);
   endtask

   task automatic take_result(input int hold, output logic [11:0] d, output logic e);
      bit ok = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (bus.res_valid) begin ok = 1; break; end
      end
      chk("res_arrives", 32'(ok), 1);
      d = bus.res_data;
      e = bus.res_err;
      @(posedge clk); #1;
      if (hold > 0) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_insn = INSN_MADD;
         repeat (hold) begin @(posedge clk); #1; end
         bus.cmd_valid = 1'b0;
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
   endtask

   task automatic run_job(input logic [1:0] insn, input int nb, input logic [11:0] stub,
                          input int hold, output logic [11:0] d, output logic e);
      stub_val = stub;
      send_cmd(insn);
      if (insn != INSN_ILLEGAL) begin
         for (int b = 0; b < nb; b++) begin
            send_beat(beat_idx[b], beat_dat[b], b == nb - 1);
            repeat (beat_gap[b]) begin @(posedge clk); #1; end
         end
      end
      take_result(hold, d, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] d;
      logic        e;
      logic [1:0]  ri;
      logic [11:0] rs;
      int          nb;
      bit          ok;

      bus.cmd_valid = 1'b0; bus.cmd_insn = '0;
      bus.op_valid = 1'b0; bus.op_index = '0; bus.op_data = '0; bus.op_last = 1'b0;
      bus.res_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk); #2;
      rst_n = 1'b1;
      #1 chk("cmd_ready_before_clock", 32'(bus.cmd_ready), 0);
      @(posedge clk); #1;
      chk("cmd_ready_after_reset", 32'(bus.cmd_ready), 1);
      chk("dm_run_after_reset", 32'(bus.dm_run), 0);

      // MIN job, contiguous beats 5,9,3
      beat_idx[0] = 4'd5; beat_idx[1] = 4'd9; beat_idx[2] = 4'd3;
      beat_dat[0] = 4'd1; beat_dat[1] = 4'd6; beat_dat[2] = 4'd8;
      beat_gap[0] = 0; beat_gap[1] = 0; beat_gap[2] = 0;
      run_job(INSN_MIN, 3, 12'h003, 0, d, e);
      chk("min_res", 32'(d), 32'h003);
      chk("min_err", 32'(e), 0);
      chk("min_loads", 32'(n_loads), 3);
      chk("min_idx0", 32'(ld_idx[0]), 5);
      chk("min_idx1", 32'(ld_idx[1]), 9);
      chk("min_idx2", 32'(ld_idx[2]), 3);
      chk("min_contig", 32'(ld_cyc[2] - ld_cyc[0]), 2);

      // MADD job with three idle cycles between beats
      beat_idx[0] = 4'd4; beat_dat[0] = 4'd2; beat_gap[0] = 3;
      beat_idx[1] = 4'd7; beat_dat[1] = 4'd5; beat_gap[1] = 0;
      run_job(INSN_MADD, 2, 12'h0A5, 0, d, e);
      chk("madd_res", 32'(d), 32'h0A5);
      chk("madd_loads", 32'(n_loads), 2);
      chk("madd_dat0", 32'(ld_dat[0]), 2);
      chk("madd_dat1", 32'(ld_dat[1]), 5);
      chk("madd_gap", 32'(ld_cyc[1] - ld_cyc[0]), 4);

      // Illegal insn
      run_job(INSN_ILLEGAL, 0, 12'h777, 0, d, e);
      chk("ill_res", 32'(d), 0);
      chk("ill_err", 32'(e), 1);

      // MAX job with ten cycles of result backpressure and a competing command
      beat_idx[0] = 4'd12; beat_dat[0] = 4'd9; beat_gap[0] = 1;
      beat_idx[1] = 4'd0;  beat_dat[1] = 4'd3; beat_gap[1] = 0;
      run_job(INSN_MAX, 2, 12'h5C1, 10, d, e);
      chk("bp_res", 32'(d), 32'h5C1);
      chk("bp_err", 32'(e), 0);

      // Random back-to-back jobs
      for (int j = 0; j < 24; j++) begin
         ri = 2'($urandom_range(0, 3));
         rs = 12'($urandom);
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin
            beat_idx[b] = 4'($urandom);
            beat_dat[b] = 4'($urandom);
            beat_gap[b] = $urandom_range(0, 2);
         end
         run_job(ri, nb, rs, $urandom_range(0, 3), d, e);
         chk("rand_res", 32'(d), (ri == INSN_ILLEGAL) ? 32'h0 : 32'(rs));
         chk("rand_err", 32'(e), 32'(ri == INSN_ILLEGAL));
      end

      // Asynchronous reset in the middle of RUN
      stub_val = 12'h321;
      send_cmd(INSN_MAX);
      send_beat(4'd1, 4'd2, 1'b1);
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.dm_run) begin ok = 1; break; end
      end
      chk("run_reached", 32'(ok), 1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midrun");
      @(negedge clk); #2;
      rst_n = 1'b1;
      #1 chk("cmd_ready_post_abort", 32'(bus.cmd_ready), 0);
      @(posedge clk); #1;
      chk("cmd_ready_after_abort", 32'(bus.cmd_ready), 1);
      chk("dm_run_after_abort", 32'(bus.dm_run), 0);

      // Recovery job after the abort
      beat_idx[0] = 4'd15; beat_dat[0] = 4'd15; beat_gap[0] = 0;
      run_job(INSN_MIN, 1, 12'hABC, 0, d, e);
      chk("recover_res", 32'(d), 32'hABC);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
